// File: rtl/ll_fifo_pkg.sv
// Shared types for the linked-list multi-queue FIFO and its pop arbiter.
// Sizes here are the default build; modules re-derive widths from their own parameters.
package ll_fifo_pkg;

  localparam int SKID_DEPTH   = 2;
  localparam int SKID_CNT_W   = $clog2(SKID_DEPTH + 1);
  localparam int SKID_PTR_W   = $clog2(SKID_DEPTH);
  localparam int LL_WIDTH     = 8;
  localparam int LL_NUM_FIFOS = 2;

  // A single queue still needs a 1-bit select so port widths never collapse to zero.
  function automatic int calc_sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LL_SEL_WIDTH = calc_sel_width(LL_NUM_FIFOS);

  typedef struct packed {
    logic [LL_SEL_WIDTH-1:0] sel;
    logic [LL_WIDTH-1:0]     data;
  } ll_entry_t;

endpackage

// File: rtl/ll_pop_skid_buffer.sv
// Two-entry FIFO of {sel, data} entries between the pop arbiter and the consumer.
// Latency: a write is visible on rd_dat the next cycle; stalls hold rd_dat stable until rd_rdy.
module ll_pop_skid_buffer
  import ll_fifo_pkg::*;
#(
  parameter type entry_t = ll_entry_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  entry_t                wr_dat,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output entry_t                rd_dat,
  output logic [SKID_CNT_W-1:0] count
);

  entry_t                mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr;
  logic [SKID_PTR_W-1:0] rd_ptr;
  logic                  wr_fire;
  logic                  rd_fire;

  assign rd_vld  = (count != '0);
  assign rd_dat  = mem[rd_ptr];
  assign wr_fire = wr_en && (count != SKID_CNT_W'(SKID_DEPTH));
  assign rd_fire = rd_vld && rd_rdy;

  // Storage is cleared too, so the output word reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + SKID_PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + SKID_PTR_W'(1);
      end
      count <= count + SKID_CNT_W'(wr_fire) - SKID_CNT_W'(rd_fire);
    end
  end

endmodule

// File: rtl/ll_fifo_pop_arbiter.sv
// Round-robin pop arbiter draining the shared linked-list FIFO into a 2-entry skid buffer.
// Latency: pop is combinational, word appears on out_data the next cycle; stops popping when the buffer is full.
// LL_POP_ARB_FORMAL_EN adds assertions, an assume steering stalls and a full-buffer cover.
module ll_fifo_pop_arbiter
  import ll_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = calc_sel_width(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  input  logic [NUM_FIFOS-1:0] queue_mask,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel
);

  typedef struct packed {
    logic [SEL_WIDTH-1:0] sel;
    logic [WIDTH-1:0]     data;
  } entry_t;

  logic [NUM_FIFOS-1:0]  eligible;
  logic [SEL_WIDTH-1:0]  last_sel;
  logic [SEL_WIDTH-1:0]  grant_sel;
  logic                  grant_vld;
  logic [SKID_CNT_W-1:0] count;
  entry_t                wr_entry;
  entry_t                rd_entry;

  // Scan starts one past the previous winner; modulo keeps indices below NUM_FIFOS.
  function automatic logic [SEL_WIDTH:0] rr_grant(input logic [NUM_FIFOS-1:0] elig,
                                                  input logic [SEL_WIDTH-1:0] last);
    logic                 found;
    logic [SEL_WIDTH-1:0] pick;
    int                   idx;
    found = 1'b0;
    pick  = last;
    for (int i = 1; i <= NUM_FIFOS; i++) begin
      idx = (int'(last) + i) % NUM_FIFOS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = SEL_WIDTH'(idx);
      end
    end
    return {found, pick};
  endfunction

  // While rst is high the upstream FIFO is also in reset, so pop stays low and pop_sel reads 0.
  always_comb begin
    eligible               = ~fifo_empty & queue_mask;
    {grant_vld, grant_sel} = rr_grant(eligible, last_sel);
    pop                    = grant_vld && (count != SKID_CNT_W'(SKID_DEPTH)) && !rst;
    pop_sel                = last_sel;
    if (rst) begin
      pop_sel = '0;
    end else if (pop) begin
      pop_sel = grant_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sel <= SEL_WIDTH'(NUM_FIFOS - 1);
    end else if (pop) begin
      last_sel <= pop_sel;
    end
  end

  assign wr_entry = '{sel: pop_sel, data: fifo_data};

  ll_pop_skid_buffer #(
    .entry_t (entry_t)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (pop),
    .wr_dat (wr_entry),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (rd_entry),
    .count  (count)
  );

  assign out_data = rd_entry.data;
  assign out_sel  = rd_entry.sel;

`ifdef LL_POP_ARB_FORMAL_EN
  always_comb begin
    if (!rst) begin
      a_sel_range: assert (int'(pop_sel) < NUM_FIFOS);
      a_count_max: assert (count <= SKID_CNT_W'(SKID_DEPTH));
    end
  end

  a_pop_legal: assert property (@(posedge clk) disable iff (rst)
    pop |-> (!fifo_empty[pop_sel] && queue_mask[pop_sel]));

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_sel)));

  // Once the consumer stalls it keeps stalling until the buffer fills.
  m_stall_hold: assume property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && (count != SKID_CNT_W'(SKID_DEPTH))) |=> !out_ready);

  c_full: cover property (@(posedge clk) disable iff (rst)
    count == SKID_CNT_W'(SKID_DEPTH));

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_starve
    logic [SEL_WIDTH:0] passed;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        passed <= '0;
      end else if (!eligible[g] || (pop && (pop_sel == SEL_WIDTH'(g)))) begin
        passed <= '0;
      end else if (pop) begin
        passed <= passed + 1'b1;
      end
    end
    a_no_starve: assert property (@(posedge clk) disable iff (rst)
      int'(passed) < NUM_FIFOS);
  end
`else
`endif

endmodule

// File: tb/tb_ll_fifo_pop_arbiter.sv
// Directed bench for ll_fifo_pop_arbiter with a two-queue model of the shared FIFO.
// Expected pop/output sequences are hand-computed per cycle.
module tb_ll_fifo_pop_arbiter;

  localparam int WIDTH     = 8;
  localparam int NUM_FIFOS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fifo_empty;
  logic [7:0] fifo_data;
  logic [1:0] queue_mask;
  logic       pop;
  logic [0:0] pop_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [0:0] out_sel;

  int checks = 0;
  int errors = 0;

  logic [7:0] qmem [2][8];
  int         qhead [2];
  int         qtail [2];
  logic       p_pop;
  logic [0:0] p_sel;

  always #5 clk = ~clk;

  ll_fifo_pop_arbiter #(
    .WIDTH     (WIDTH),
    .NUM_FIFOS (NUM_FIFOS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .queue_mask (queue_mask),
    .pop        (pop),
    .pop_sel    (pop_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sel    (out_sel)
  );

  // Upstream FIFO model: head word of the selected queue, empty when head meets tail.
  always_comb begin
    fifo_empty[0] = (qhead[0] == qtail[0]);
    fifo_empty[1] = (qhead[1] == qtail[1]);
    fifo_data     = (pop_sel == 1'b1) ? qmem[1][qhead[1][2:0]] : qmem[0][qhead[0][2:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_cycle(input string tag, input logic e_pop, input logic e_sel,
                              input logic e_vld, input logic [7:0] e_dat, input logic e_osel);
    check({tag, "_pop"}, 32'(pop), 32'(e_pop));
    check({tag, "_pop_sel"}, 32'(pop_sel), 32'(e_sel));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(e_vld));
    if (e_vld) begin
      check({tag, "_out_data"}, 32'(out_data), 32'(e_dat));
      check({tag, "_out_sel"}, 32'(out_sel), 32'(e_osel));
    end
  endtask

  task automatic push(input int q, input logic [7:0] v);
    qmem[q][qtail[q][2:0]] = v;
    qtail[q] = qtail[q] + 1;
  endtask

  task automatic flush_queues();
    for (int q = 0; q < 2; q++) begin
      qhead[q] = 0;
      qtail[q] = 0;
    end
  endtask

  // Sample the pop decision mid-cycle, then retire the popped word just after the edge.
  task automatic tick();
    @(negedge clk);
    p_pop = pop;
    p_sel = pop_sel;
    @(posedge clk);
    #1;
    if (p_pop) qhead[p_sel] = qhead[p_sel] + 1;
    #1;
  endtask

  initial begin
    flush_queues();
    out_ready  = 1'b1;
    queue_mask = 2'b11;
    rst        = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_pop_sel", 32'(pop_sel), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    #9 rst = 1'b0;
    @(posedge clk);
    #2;

    // Idle after reset: nothing eligible, last_sel parked at queue 1.
    for (int i = 0; i < 10; i++) begin
      expect_cycle("idle", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      tick();
    end

    // Alternating drain of two queues.
    push(0, 8'hA1); push(0, 8'hA2);
    push(1, 8'hB1); push(1, 8'hB2);
    #1;
    expect_cycle("rr_c0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    expect_cycle("rr_c1", 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0); tick();
    expect_cycle("rr_c2", 1'b1, 1'b0, 1'b1, 8'hB1, 1'b1); tick();
    expect_cycle("rr_c3", 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0); tick();
    expect_cycle("rr_c4", 1'b0, 1'b1, 1'b1, 8'hB2, 1'b1); tick();
    expect_cycle("rr_c5", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Backpressure: buffer fills at two words, then drains in order once ready returns.
    out_ready = 1'b0;
    push(0, 8'hC1); push(0, 8'hC2); push(0, 8'hC3); push(0, 8'hC4);
    #1;
    expect_cycle("bp_c0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    expect_cycle("bp_c1", 1'b1, 1'b0, 1'b1, 8'hC1, 1'b0); tick();
    expect_cycle("bp_c2", 1'b0, 1'b0, 1'b1, 8'hC1, 1'b0); tick();
    expect_cycle("bp_c3", 1'b0, 1'b0, 1'b1, 8'hC1, 1'b0); tick();
    out_ready = 1'b1;
    #1;
    expect_cycle("bp_c4", 1'b0, 1'b0, 1'b1, 8'hC1, 1'b0); tick();
    expect_cycle("bp_c5", 1'b1, 1'b0, 1'b1, 8'hC2, 1'b0); tick();
    expect_cycle("bp_c6", 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0); tick();
    expect_cycle("bp_c7", 1'b0, 1'b0, 1'b1, 8'hC4, 1'b0); tick();
    expect_cycle("bp_c8", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Mask: only queue 1 drains until queue 0 is re-enabled.
    queue_mask = 2'b10;
    push(0, 8'hD1); push(0, 8'hD2);
    push(1, 8'hE1); push(1, 8'hE2); push(1, 8'hE3);
    #1;
    expect_cycle("mask_c0", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    expect_cycle("mask_c1", 1'b1, 1'b1, 1'b1, 8'hE1, 1'b1); tick();
    queue_mask = 2'b11;
    #1;
    expect_cycle("mask_c2", 1'b1, 1'b0, 1'b1, 8'hE2, 1'b1); tick();
    expect_cycle("mask_c3", 1'b1, 1'b1, 1'b1, 8'hD1, 1'b0); tick();
    expect_cycle("mask_c4", 1'b1, 1'b0, 1'b1, 8'hE3, 1'b1); tick();
    expect_cycle("mask_c5", 1'b0, 1'b0, 1'b1, 8'hD2, 1'b0); tick();
    expect_cycle("mask_c6", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset with a full buffer.
    out_ready = 1'b0;
    push(1, 8'hF1); push(1, 8'hF2); push(1, 8'hF3);
    #1;
    expect_cycle("ar_c0", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    expect_cycle("ar_c1", 1'b1, 1'b1, 1'b1, 8'hF1, 1'b1); tick();
    expect_cycle("ar_c2", 1'b0, 1'b1, 1'b1, 8'hF1, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_sel", 32'(out_sel), 32'd0);
    check("arst_pop", 32'(pop), 32'd0);
    check("arst_pop_sel", 32'(pop_sel), 32'd0);
    flush_queues();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    push(0, 8'h61); push(1, 8'h71);
    #1;
    expect_cycle("post_c0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    expect_cycle("post_c1", 1'b1, 1'b1, 1'b1, 8'h61, 1'b0); tick();
    expect_cycle("post_c2", 1'b0, 1'b1, 1'b1, 8'h71, 1'b1); tick();
    expect_cycle("post_c3", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
